// File: rtl/mem_stage_wb_pkg.sv
// Shared Y86-64 encodings, widths and the W-register bundle
// used by the memory stage and its W pipeline register.
package mem_stage_wb_pkg;

   localparam int NIBBLE = 4;
   localparam int D_WORD = 64;

   typedef logic [NIBBLE-1:0] nib_t;
   typedef logic [D_WORD-1:0] word_t;

   localparam nib_t IHALT   = 4'h0;
   localparam nib_t INOP    = 4'h1;
   localparam nib_t IRMMOVQ = 4'h4;
   localparam nib_t IMRMOVQ = 4'h5;
   localparam nib_t IOPQ    = 4'h6;
   localparam nib_t ICALL   = 4'h8;
   localparam nib_t IRET    = 4'h9;
   localparam nib_t IPUSHQ  = 4'hA;
   localparam nib_t IPOPQ   = 4'hB;

   localparam nib_t SAOK = 4'h1;
   localparam nib_t SHLT = 4'h2;
   localparam nib_t SADR = 4'h3;
   localparam nib_t SINS = 4'h4;

   localparam nib_t RNONE = 4'hF;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } dmem_st_e;

   typedef struct packed {
      nib_t  stat;
      nib_t  icode;
      word_t val_e;
      word_t val_m;
      nib_t  dst_e;
      nib_t  dst_m;
   } w_t;

   function automatic logic is_rd(input nib_t ic);
      return (ic == IMRMOVQ) || (ic == IPOPQ) || (ic == IRET);
   endfunction

   function automatic logic is_wr(input nib_t ic);
      return (ic == IRMMOVQ) || (ic == IPUSHQ) || (ic == ICALL);
   endfunction

   function automatic w_t w_bubble();
      w_t b;
      b.stat  = SAOK;
      b.icode = INOP;
      b.val_e = '0;
      b.val_m = '0;
      b.dst_e = RNONE;
      b.dst_m = RNONE;
      return b;
   endfunction

endpackage

// File: rtl/mem_stage_wb_wb_reg.sv
// W pipeline register: stall holds, bubble inserts a NOP,
// otherwise the memory-stage result is loaded.
module mem_stage_wb_wb_reg
   import mem_stage_wb_pkg::*;
(
   input  logic clk_i,
   input  logic rstn_i,
   input  logic stall_i,
   input  logic bubble_i,
   input  w_t   d_i,
   output w_t   q_o
);

   w_t w_d;
   w_t w_q;

   // next W value: hold beats bubble beats load
   always_comb begin
      w_d = w_q;
      if (stall_i) begin
         w_d = w_q;
      end else if (bubble_i) begin
         w_d = w_bubble();
      end else begin
         w_d = d_i;
      end
   end

   // W register, cleared to all zeros on reset
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         w_q <= '0;
      end else begin
         w_q <= w_d;
      end
   end

   assign q_o = w_q;

endmodule

// File: rtl/mem_stage_wb.sv
// Y86-64 memory stage: data-memory req/ack access, forwarding, W load.
// DMEM_TIMEOUT_EN: abort a WAIT after TIMEOUT_CYCLES cycles with SADR.
module mem_stage_wb
   import mem_stage_wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [3:0]  M_stat_i,
   input  logic [3:0]  M_icode_i,
   input  logic [63:0] M_valE_i,
   input  logic [63:0] M_valA_i,
   input  logic [3:0]  M_dstE_i,
   input  logic [3:0]  M_dstM_i,
   input  logic        W_stall_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [63:0] dmem_addr_o,
   output logic [63:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [63:0] dmem_rdata_i,
   input  logic        dmem_err_i,
   output logic        m_stall_o,
   output logic [3:0]  m_stat_o,
   output logic [63:0] m_valM_o,
   output logic [3:0]  W_stat_o,
   output logic [3:0]  W_icode_o,
   output logic [63:0] W_valE_o,
   output logic [63:0] W_valM_o,
   output logic [3:0]  W_dstE_o,
   output logic [3:0]  W_dstM_o
);

   dmem_st_e state_q;
   dmem_st_e state_d;

   logic rd;
   logic wr;
   logic mem_op;
   logic ack_done;
   logic timeout;
   logic done;
   logic mem_err;
   w_t   w_in;
   w_t   w_out;

   logic cfg_unused;
   assign cfg_unused = (TIMEOUT_CYCLES < (1 << CNT_W));

`ifdef DMEM_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
`endif

   // decode, address mux, handshake, forwarding and next state
   always_comb begin
      rd       = is_rd(M_icode_i);
      wr       = is_wr(M_icode_i);
      mem_op   = (rd || wr) && (M_stat_i == SAOK);
      dmem_we_o    = wr;
      dmem_wdata_o = M_valA_i;
      dmem_addr_o  = M_valE_i;
      if ((M_icode_i == IPOPQ) || (M_icode_i == IRET)) begin
         dmem_addr_o = M_valA_i;
      end
      dmem_req_o = rstn_i &&
                   (((state_q == ST_IDLE) && mem_op && !W_stall_i) ||
                    (state_q == ST_WAIT));
      ack_done = dmem_req_o && dmem_ack_i;
      timeout  = 1'b0;
`ifdef DMEM_TIMEOUT_EN
      timeout  = dmem_req_o && !dmem_ack_i && (state_q == ST_WAIT) &&
                 (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
      done     = ack_done || timeout;
      mem_err  = (ack_done && dmem_err_i) || timeout;
      m_stall_o = mem_op && !done;
      m_stat_o  = mem_err ? SADR : M_stat_i;
      m_valM_o  = (ack_done && rd) ? dmem_rdata_i : '0;

      w_in.stat  = m_stat_o;
      w_in.icode = M_icode_i;
      w_in.val_e = M_valE_i;
      w_in.val_m = m_valM_o;
      w_in.dst_e = M_dstE_i;
      w_in.dst_m = mem_err ? RNONE : M_dstM_i;

      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (dmem_req_o && !done) state_d = ST_WAIT;
         ST_WAIT: if (done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // access state register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef DMEM_TIMEOUT_EN
   // wait counter: counts WAIT cycles, cleared when WAIT is left
   always_comb begin
      cnt_d = '0;
      if ((state_q == ST_WAIT) && !done) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // wait counter register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   mem_stage_wb_wb_reg u_wb_reg (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .stall_i  (W_stall_i),
      .bubble_i (m_stall_o),
      .d_i      (w_in),
      .q_o      (w_out)
   );

   assign W_stat_o  = w_out.stat;
   assign W_icode_o = w_out.icode;
   assign W_valE_o  = w_out.val_e;
   assign W_valM_o  = w_out.val_m;
   assign W_dstE_o  = w_out.dst_e;
   assign W_dstM_o  = w_out.dst_m;

   // W is never stalled while an access is outstanding
   a_no_wstall_in_wait: assert property (
      @(posedge clk_i) disable iff (!rstn_i)
      !((state_q == ST_WAIT) && W_stall_i));

endmodule

// File: tb/tb_mem_stage_wb.sv
// Directed table-driven bench for mem_stage_wb
// plus multi-cycle wait, reset and timeout sequences.
module tb_mem_stage_wb;

   logic        clk_i;
   logic        rstn_i;
   logic [3:0]  M_stat_i;
   logic [3:0]  M_icode_i;
   logic [63:0] M_valE_i;
   logic [63:0] M_valA_i;
   logic [3:0]  M_dstE_i;
   logic [3:0]  M_dstM_i;
   logic        W_stall_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [63:0] dmem_addr_o;
   logic [63:0] dmem_wdata_o;
   logic        dmem_ack_i;
   logic [63:0] dmem_rdata_i;
   logic        dmem_err_i;
   logic        m_stall_o;
   logic [3:0]  m_stat_o;
   logic [63:0] m_valM_o;
   logic [3:0]  W_stat_o;
   logic [3:0]  W_icode_o;
   logic [63:0] W_valE_o;
   logic [63:0] W_valM_o;
   logic [3:0]  W_dstE_o;
   logic [3:0]  W_dstM_o;

   int total = 0;
   int bad   = 0;

   mem_stage_wb #(
      .TIMEOUT_CYCLES(4),
      .CNT_W(8)
   ) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .M_stat_i     (M_stat_i),
      .M_icode_i    (M_icode_i),
      .M_valE_i     (M_valE_i),
      .M_valA_i     (M_valA_i),
      .M_dstE_i     (M_dstE_i),
      .M_dstM_i     (M_dstM_i),
      .W_stall_i    (W_stall_i),
      .dmem_req_o   (dmem_req_o),
      .dmem_we_o    (dmem_we_o),
      .dmem_addr_o  (dmem_addr_o),
      .dmem_wdata_o (dmem_wdata_o),
      .dmem_ack_i   (dmem_ack_i),
      .dmem_rdata_i (dmem_rdata_i),
      .dmem_err_i   (dmem_err_i),
      .m_stall_o    (m_stall_o),
      .m_stat_o     (m_stat_o),
      .m_valM_o     (m_valM_o),
      .W_stat_o     (W_stat_o),
      .W_icode_o    (W_icode_o),
      .W_valE_o     (W_valE_o),
      .W_valM_o     (W_valM_o),
      .W_dstE_o     (W_dstE_o),
      .W_dstM_o     (W_dstM_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  stat;
      logic [3:0]  icode;
      logic [63:0] val_e;
      logic [63:0] val_a;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
      logic        ack;
      logic [63:0] rdata;
      logic        err;
      logic        wst;
      logic        x_req;
      logic        x_we;
      logic [63:0] x_addr;
      logic        x_stall;
      logic [3:0]  x_mstat;
      logic [63:0] x_mvalm;
      logic [3:0]  x_ws;
      logic [3:0]  x_wi;
      logic [63:0] x_wve;
      logic [63:0] x_wvm;
      logic [3:0]  x_wde;
      logic [3:0]  x_wdm;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] st, input logic [3:0] ic,
                        input logic [63:0] ve, input logic [63:0] va,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic ack, input logic [63:0] rdat,
                        input logic err, input logic wst);
      M_stat_i     = st;
      M_icode_i    = ic;
      M_valE_i     = ve;
      M_valA_i     = va;
      M_dstE_i     = de;
      M_dstM_i     = dm;
      dmem_ack_i   = ack;
      dmem_rdata_i = rdat;
      dmem_err_i   = err;
      W_stall_i    = wst;
   endtask

   task automatic chk_w_zero(input string tag);
      chk({tag, " W_stat"},  64'(W_stat_o),  64'h0);
      chk({tag, " W_icode"}, 64'(W_icode_o), 64'h0);
      chk({tag, " W_valE"},  W_valE_o,       64'h0);
      chk({tag, " W_valM"},  W_valM_o,       64'h0);
      chk({tag, " W_dstE"},  64'(W_dstE_o),  64'h0);
      chk({tag, " W_dstM"},  64'(W_dstM_o),  64'h0);
   endtask

   initial begin
      tbl[0] = '{4'h1, 4'h5, 64'h100, 64'h7, 4'hF, 4'h3, 1'b1,
                 64'hDEAD, 1'b0, 1'b0,
                 1'b1, 1'b0, 64'h100, 1'b0, 4'h1, 64'hDEAD,
                 4'h1, 4'h5, 64'h100, 64'hDEAD, 4'hF, 4'h3};
      tbl[1] = '{4'h1, 4'h4, 64'h180, 64'h55, 4'hF, 4'hF, 1'b1,
                 64'h1234, 1'b0, 1'b0,
                 1'b1, 1'b1, 64'h180, 1'b0, 4'h1, 64'h0,
                 4'h1, 4'h4, 64'h180, 64'h0, 4'hF, 4'hF};
      tbl[2] = '{4'h1, 4'hB, 64'h208, 64'h200, 4'h4, 4'h2, 1'b1,
                 64'h99, 1'b1, 1'b0,
                 1'b1, 1'b0, 64'h200, 1'b0, 4'h3, 64'h99,
                 4'h3, 4'hB, 64'h208, 64'h99, 4'h4, 4'hF};
      tbl[3] = '{4'h1, 4'h6, 64'h42, 64'h0, 4'h3, 4'hF, 1'b1,
                 64'h77, 1'b0, 1'b0,
                 1'b0, 1'b0, 64'h42, 1'b0, 4'h1, 64'h0,
                 4'h1, 4'h6, 64'h42, 64'h0, 4'h3, 4'hF};
      tbl[4] = '{4'h4, 4'h5, 64'h300, 64'h0, 4'hF, 4'h5, 1'b1,
                 64'hAA, 1'b0, 1'b0,
                 1'b0, 1'b0, 64'h300, 1'b0, 4'h4, 64'h0,
                 4'h4, 4'h5, 64'h300, 64'h0, 4'hF, 4'h5};
      tbl[5] = '{4'h1, 4'h9, 64'h10, 64'h500, 4'h4, 4'hF, 1'b1,
                 64'hBEEF, 1'b0, 1'b0,
                 1'b1, 1'b0, 64'h500, 1'b0, 4'h1, 64'hBEEF,
                 4'h1, 4'h9, 64'h10, 64'hBEEF, 4'h4, 4'hF};
      tbl[6] = '{4'h1, 4'h8, 64'h1F0, 64'h30, 4'h4, 4'hF, 1'b1,
                 64'h0, 1'b0, 1'b0,
                 1'b1, 1'b1, 64'h1F0, 1'b0, 4'h1, 64'h0,
                 4'h1, 4'h8, 64'h1F0, 64'h0, 4'h4, 4'hF};
      tbl[7] = '{4'h1, 4'h5, 64'h600, 64'h0, 4'hF, 4'h1, 1'b1,
                 64'h5A5A, 1'b0, 1'b1,
                 1'b0, 1'b0, 64'h600, 1'b1, 4'h1, 64'h0,
                 4'h1, 4'h8, 64'h1F0, 64'h0, 4'h4, 4'hF};
      tbl[8] = '{4'h2, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0,
                 64'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 64'h0, 1'b0, 4'h2, 64'h0,
                 4'h2, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF};

      rstn_i = 1'b0;
      drive(4'h1, 4'h5, 64'h100, 64'h0, 4'hF, 4'h3,
            1'b0, 64'h0, 1'b0, 1'b0);
      #2;
      chk("rst req", 64'(dmem_req_o), 64'h0);
      chk_w_zero("rst");
      @(negedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;

      for (int i = 0; i < 9; i++) begin
         @(negedge clk_i);
         drive(tbl[i].stat, tbl[i].icode, tbl[i].val_e, tbl[i].val_a,
               tbl[i].dst_e, tbl[i].dst_m, tbl[i].ack, tbl[i].rdata,
               tbl[i].err, tbl[i].wst);
         #1;
         chk($sformatf("v%0d req", i),   64'(dmem_req_o), 64'(tbl[i].x_req));
         chk($sformatf("v%0d we", i),    64'(dmem_we_o),  64'(tbl[i].x_we));
         chk($sformatf("v%0d addr", i),  dmem_addr_o,     tbl[i].x_addr);
         chk($sformatf("v%0d wdata", i), dmem_wdata_o,    tbl[i].val_a);
         chk($sformatf("v%0d stall", i), 64'(m_stall_o),  64'(tbl[i].x_stall));
         chk($sformatf("v%0d mstat", i), 64'(m_stat_o),   64'(tbl[i].x_mstat));
         chk($sformatf("v%0d mvalM", i), m_valM_o,        tbl[i].x_mvalm);
         @(posedge clk_i);
         #1;
         chk($sformatf("v%0d W_stat", i),  64'(W_stat_o),  64'(tbl[i].x_ws));
         chk($sformatf("v%0d W_icode", i), 64'(W_icode_o), 64'(tbl[i].x_wi));
         chk($sformatf("v%0d W_valE", i),  W_valE_o,       tbl[i].x_wve);
         chk($sformatf("v%0d W_valM", i),  W_valM_o,       tbl[i].x_wvm);
         chk($sformatf("v%0d W_dstE", i),  64'(W_dstE_o),  64'(tbl[i].x_wde));
         chk($sformatf("v%0d W_dstM", i),  64'(W_dstM_o),  64'(tbl[i].x_wdm));
      end

      // push with three stalled cycles then ack
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         drive(4'h1, 4'hA, 64'h1F8, 64'h55, 4'h4, 4'hF,
               (k == 3), 64'h0, 1'b0, 1'b0);
         #1;
         chk($sformatf("push%0d req", k),   64'(dmem_req_o),  64'h1);
         chk($sformatf("push%0d we", k),    64'(dmem_we_o),   64'h1);
         chk($sformatf("push%0d addr", k),  dmem_addr_o,      64'h1F8);
         chk($sformatf("push%0d wdata", k), dmem_wdata_o,     64'h55);
         chk($sformatf("push%0d stall", k), 64'(m_stall_o),   64'(k != 3));
         @(posedge clk_i);
         #1;
         chk($sformatf("push%0d W_icode", k), 64'(W_icode_o),
             (k == 3) ? 64'hA : 64'h1);
         chk($sformatf("push%0d W_dstE", k), 64'(W_dstE_o),
             (k == 3) ? 64'h4 : 64'hF);
         chk($sformatf("push%0d W_valE", k), W_valE_o,
             (k == 3) ? 64'h1F8 : 64'h0);
      end
      @(negedge clk_i);
      drive(4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF,
            1'b0, 64'h0, 1'b0, 1'b0);
      #1;
      chk("push idle req", 64'(dmem_req_o), 64'h0);
      @(posedge clk_i);

      // reset while waiting abandons the access
      @(negedge clk_i);
      drive(4'h1, 4'h5, 64'h700, 64'h0, 4'hF, 4'h3,
            1'b0, 64'h0, 1'b0, 1'b0);
      #1;
      chk("rw req", 64'(dmem_req_o), 64'h1);
      @(posedge clk_i);
      #2;
      chk("rw wait req", 64'(dmem_req_o), 64'h1);
      chk("rw bubble icode", 64'(W_icode_o), 64'h1);
      rstn_i = 1'b0;
      #1;
      chk("rw async req", 64'(dmem_req_o), 64'h0);
      chk_w_zero("rw");
      @(negedge clk_i);
      drive(4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF,
            1'b0, 64'h0, 1'b0, 1'b0);
      #1;
      rstn_i = 1'b1;
      #1;
      chk("rw idle req", 64'(dmem_req_o), 64'h0);
      chk("rw idle stall", 64'(m_stall_o), 64'h0);

`ifdef DMEM_TIMEOUT_EN
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         drive(4'h1, 4'h5, 64'h800, 64'h0, 4'hF, 4'h6,
               1'b0, 64'hFFFF, 1'b0, 1'b0);
         #1;
         chk($sformatf("to%0d req", k),   64'(dmem_req_o), 64'h1);
         chk($sformatf("to%0d stall", k), 64'(m_stall_o),  64'(k != 4));
         chk($sformatf("to%0d mstat", k), 64'(m_stat_o),
             (k == 4) ? 64'h3 : 64'h1);
         chk($sformatf("to%0d mvalM", k), m_valM_o, 64'h0);
         @(posedge clk_i);
      end
      #1;
      chk("to W_stat", 64'(W_stat_o), 64'h3);
      chk("to W_icode", 64'(W_icode_o), 64'h5);
      chk("to W_dstM", 64'(W_dstM_o), 64'hF);
      @(negedge clk_i);
      drive(4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF,
            1'b1, 64'h1234, 1'b1, 1'b0);
      #1;
      chk("to late req", 64'(dmem_req_o), 64'h0);
      chk("to late mstat", 64'(m_stat_o), 64'h1);
      chk("to late mvalM", m_valM_o, 64'h0);
      @(posedge clk_i);
      #1;
      chk("to late W_stat", 64'(W_stat_o), 64'h1);
      chk("to late W_icode", 64'(W_icode_o), 64'h1);
`else
      for (int k = 0; k < 22; k++) begin
         @(negedge clk_i);
         drive(4'h1, 4'h5, 64'h800, 64'h0, 4'hF, 4'h6,
               1'b0, 64'hFFFF, 1'b0, 1'b0);
         #1;
         chk($sformatf("hold%0d req", k),   64'(dmem_req_o), 64'h1);
         chk($sformatf("hold%0d stall", k), 64'(m_stall_o),  64'h1);
         @(posedge clk_i);
      end
      @(negedge clk_i);
      drive(4'h1, 4'h5, 64'h800, 64'h0, 4'hF, 4'h6,
            1'b1, 64'h1111, 1'b0, 1'b0);
      #1;
      chk("hold ack stall", 64'(m_stall_o), 64'h0);
      chk("hold ack mvalM", m_valM_o, 64'h1111);
      @(posedge clk_i);
      #1;
      chk("hold W_valM", W_valM_o, 64'h1111);
      chk("hold W_dstM", 64'(W_dstM_o), 64'h6);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage_wb.md
Name: mem_stage_wb

Overview:
- Consumer end of the E->M pipeline register in the Y86-64 five-stage pipeline.
- Takes the M_* fields, performs the data-memory access over a req/ack handshake, and produces m_valM/m_stat for forwarding.
- Loads the W pipeline register.
- Stalls M (via hazard unit) while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles WAIT may last before error (only with DMEM_TIMEOUT_EN)
- CNT_W, 8, width of wait counter; TIMEOUT_CYCLES < 2**CNT_W

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- M_stat_i  in  4  stat from M register
- M_icode_i  in  4  icode from M register
- M_valE_i  in  64  ALU result / address
- M_valA_i  in  64  store data / pop-ret address
- M_dstE_i  in  4  dest reg E
- M_dstM_i  in  4  dest reg M
- W_stall_i  in  1  hazard unit: hold W
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  1=write, 0=read
- dmem_addr_o  out  64  byte address
- dmem_wdata_o  out  64  write data
- dmem_ack_i  in  1  access complete (1-cycle pulse)
- dmem_rdata_i  in  64  read data, valid with ack
- dmem_err_i  in  1  bad address, valid with ack
- m_stall_o  out  1  to hazard unit: hold M, bubble W
- m_stat_o  out  4  forwarded stat (comb)
- m_valM_o  out  64  forwarded load data (comb)
- W_stat_o, W_icode_o  out  4 each  W register
- W_valE_o, W_valM_o  out  64 each  W register
- W_dstE_o, W_dstM_o  out  4 each  W register

Behaviour:
- Reset:
  - All W_* = 0.
  - State = IDLE.
  - dmem_req_o = 0, counter = 0.
  - Reset asserted mid-access drops req immediately; the access is abandoned.
- Decode:
  - rd = icode in {IMRMOVQ, IPOPQ, IRET}.
  - wr = icode in {IRMMOVQ, IPUSHQ, ICALL}.
  - mem_op = (rd|wr) && M_stat_i==SAOK.
- Address mux:
  - addr = M_valA_i for IPOPQ/IRET.
  - addr = M_valE_i for the other memory ops.
  - wdata = M_valA_i; we = wr.
- Request (combinational):
  - dmem_req_o = (IDLE && mem_op && !W_stall_i) || WAIT.
  - addr/we/wdata must hold stable while req is high; M is held by the stall.
- FSM IDLE:
  - req && ack same cycle: zero-wait completion, stay IDLE.
  - req && !ack: go to WAIT.
- FSM WAIT:
  - ack: go to IDLE.
  - Counter increments each WAIT cycle and clears on leaving WAIT.
- Stall: m_stall_o = mem_op && !(dmem_req_o && dmem_ack_i).
- m_stat_o:
  - SADR if completing with dmem_err_i=1.
  - Otherwise M_stat_i.
- m_valM_o: dmem_rdata_i on completing read; otherwise 0.
- W register update on posedge clk_i:
  - W_stall_i=1: hold.
  - Else m_stall_o=1: bubble (stat SAOK, icode INOP, dstE=dstM=RNONE, valE=valM=0).
  - Else load m_stat_o, M_icode_i, M_valE_i, m_valM_o, M_dstE_i, M_dstM_o.
  - Err: W_dstM = RNONE on SADR.
- M_stat_i != SAOK: no request; fields pass through to W unchanged.
- W_stall_i=1 while in WAIT is illegal (unreachable, since W holds a bubble); covered by assertion.
- Ack while not requesting is ignored.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - In WAIT, when counter reaches TIMEOUT_CYCLES without ack, the access completes that cycle with m_stat_o=SADR and m_valM_o=0.
  - dmem_req_o drops next cycle and FSM returns to IDLE.
  - A late ack in IDLE with no request is ignored.
- Undefined:
  - No counter logic.
  - WAIT persists indefinitely until ack.

Decomposition:
- Shared package/include (define.v): NIBBLE/D_WORD widths, icodes (INOP, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ), stats (SAOK, SADR, SINS, SHLT), RNONE, FSM state encodings.
- One natural sub-module, wb_reg: the W pipeline register with load/bubble/stall priority. The FSM, mux and counter stay in the top.

Test Plan:
- IMRMOVQ, valE=0x100, ack same cycle, rdata=0xDEAD -> req 1 cycle, we=0, addr 0x100, no stall, next edge W_valM=0xDEAD.
- IPUSHQ, valE=0x1F8, valA=0x55, ack after 3 cycles -> m_stall_o high 3 cycles, W gets 3 bubbles (icode INOP), then W_icode=IPUSHQ, dmem_wdata_o=0x55 stable throughout.
- IPOPQ, valA=0x200, ack with err=1 -> addr 0x200, W_stat=SADR, W_dstM=RNONE.
- IOPQ (non-memory) and IMRMOVQ with M_stat=SINS -> dmem_req_o never asserts, W loads fields unchanged next edge.
- rstn_i dropped during WAIT -> req deasserts without clock, all W_*=0, IDLE after release.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> completion with SADR on 4th WAIT cycle, req low after; without macro req held 20+ cycles.
